// File: rtl/serial_arith_defs.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state codes and default width.
package serial_arith_defs;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int unsigned WIDTH_DEFAULT = 4;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell, shared with the ripple-carry parallel adders.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit add/subtract, LSB first, one full_adder slice plus a carry flop.
// start/busy/done handshake; result, cout and overflow are held until the next completion.
module serial_add_sub
  import serial_arith_defs::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             fa_sum, fa_cout;

  full_adder u_fa (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    sr_d     = sr_q;
    result_d = result_q;
    count_d  = count_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // Subtract as a + ~b + 1: the +1 enters through the initial carry.
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          count_d = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        sr_d    = {fa_sum, sr_q[WIDTH-1:1]};
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        carry_d = fa_cout;
        if (count_q == LastCnt) begin
          result_d = {fa_sum, sr_q[WIDTH-1:1]};
          cout_d   = fa_cout;
          // Signed overflow: carry into the sign bit differs from carry out of it.
          ovf_d    = carry_q ^ fa_cout;
          state_d  = ST_DONE;
        end else begin
          count_d = count_q + CntW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      sr_q     <= '0;
      result_q <= '0;
      count_q  <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sr_q     <= sr_d;
      result_q <= result_d;
      count_q  <= count_d;
      carry_q  <= carry_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy     = (state_q == ST_SHIFT);
  assign done     = (state_q == ST_DONE);
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and exhaustive checks of serial_add_sub at WIDTH=4.
module tb_serial_add_sub;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         cout;
  logic         overflow;

  int errors = 0;
  int checks = 0;

  serial_add_sub #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one op, scramble inputs while busy, return cycles from accept to done.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                        output int n);
    a = ia; b = ib; sub = isub; start = 1'b1;
    step();
    start = 1'b0;
    a = ~ia; b = ib + 4'd3; sub = ~isub;
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] er, input logic ec,
                           input logic eo);
    check({tag, "_result"}, 32'(result), 32'(er));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(overflow), 32'(eo));
  endtask

  initial begin
    int n;
    logic [W:0]   full;
    logic [W-1:0] er;
    logic         eo;
    bit           saw_done;

    rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    step(); step();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check_res("rst", 4'd0, 1'b0, 1'b0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (busy || done) n++;
    end
    check("idle_quiet", n, 0);

    // Add 5+3: busy four cycles, then done with 1000, overflow set.
    a = 4'd5; b = 4'd3; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy && !done) n++;
      step();
    end
    check("add_busy_cycles", n, 4);
    check("add_done", 32'(done), 1);
    check("add_busy_at_done", 32'(busy), 0);
    check_res("add", 4'b1000, 1'b0, 1'b1);
    step();
    check("add_done_pulse", 32'(done), 0);
    check_res("add_hold", 4'b1000, 1'b0, 1'b1);

    run_op(4'd7, 4'd2, 1'b1, n);
    check("sub1_lat", n, 4);
    check_res("sub1", 4'b0101, 1'b1, 1'b0);
    step();
    run_op(4'd2, 4'd7, 1'b1, n);
    check("sub2_lat", n, 4);
    check_res("sub2", 4'b1011, 1'b0, 1'b0);
    step();
    run_op(4'b1000, 4'd1, 1'b1, n);
    check("subovf_lat", n, 4);
    check_res("subovf", 4'b0111, 1'b1, 1'b1);
    step();

    // start pulsed mid-SHIFT must be ignored.
    a = 4'd7; b = 4'd2; sub = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    a = 4'd1; b = 4'd1; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    n = 2;
    while (!done && n < 20) begin
      step();
      n++;
    end
    check("ign_lat", n, 4);
    check_res("ign", 4'b0101, 1'b1, 1'b0);
    step();
    check("ign_no_restart", 32'(busy), 0);

    // start held in DONE: back-to-back, done pulses WIDTH+1 apart.
    run_op(4'd5, 4'd3, 1'b0, n);
    check("b2b_first", 32'(done), 1);
    a = 4'd2; b = 4'd7; sub = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      step();
      n++;
    end
    check("b2b_spacing", n, 5);
    check_res("b2b", 4'b1011, 1'b0, 1'b0);
    step();

    // Reset mid-operation at bit 2.
    a = 4'd6; b = 4'd5; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_busy", 32'(busy), 0);
    check("mrst_done", 32'(done), 0);
    check_res("mrst", 4'd0, 1'b0, 1'b0);
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done || busy) saw_done = 1'b1;
    end
    check("mrst_no_done", 32'(saw_done), 0);

    // Exhaustive sweep against a reference model.
    for (int s = 0; s < 2; s++) begin
      for (int ia = 0; ia < 16; ia++) begin
        for (int ib = 0; ib < 16; ib++) begin
          if (s == 0) full = {1'b0, 4'(ia)} + {1'b0, 4'(ib)};
          else        full = {1'b0, 4'(ia)} + {1'b0, ~4'(ib)} + 5'd1;
          er = full[W-1:0];
          if (s == 0) eo = (ia[3] == ib[3]) && (er[3] != ia[3]);
          else        eo = (ia[3] != ib[3]) && (er[3] != ia[3]);
          run_op(4'(ia), 4'(ib), s[0], n);
          check("sweep_lat", n, 4);
          check_res($sformatf("sweep_%0d_%0d_%0d", s, ia, ib), er, full[W], eo);
          step();
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
